// File: rtl/stage_mem_seq_if.sv
// Interface bundling the stage-memory sequencer's control, memory-read and operand-stream signals.
// The master modport is the sequencer side; the slave modport is its environment.
interface stage_mem_seq_if #(
  parameter int DATA_DEPTH = 64,
  parameter int TAP_DEPTH  = 16,
  parameter int BIAS_DEPTH = 8
);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int TAW = $clog2(TAP_DEPTH);
  localparam int BAW = $clog2(BIAS_DEPTH);
  localparam int NIW = $clog2(DATA_DEPTH + 1);
  localparam int NOW = $clog2(BIAS_DEPTH + 1);

  logic             start;
  logic [NIW-1:0]   cfg_n_in;
  logic [NOW-1:0]   cfg_n_out;
  logic             busy;
  logic             done;
  logic             data_rd_en;
  logic [DAW-1:0]   data_rd_addr;
  logic [31:0]      data_rd_data;
  logic             tap_rd_en;
  logic [TAW-1:0]   tap_rd_addr;
  logic [191:0]     tap_rd_data;
  logic             bias_rd_en;
  logic [BAW-1:0]   bias_rd_addr;
  logic [31:0]      bias_rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [191:0]     out_tap;
  logic [31:0]      out_bias;
  logic             out_first;
  logic             out_last;

  modport master (
    input  start, cfg_n_in, cfg_n_out, data_rd_data, tap_rd_data, bias_rd_data, out_ready,
    output busy, done, data_rd_en, data_rd_addr, tap_rd_en, tap_rd_addr,
           bias_rd_en, bias_rd_addr, out_valid, out_data, out_tap, out_bias, out_first, out_last
  );

  modport slave (
    output start, cfg_n_in, cfg_n_out, data_rd_data, tap_rd_data, bias_rd_data, out_ready,
    input  busy, done, data_rd_en, data_rd_addr, tap_rd_en, tap_rd_addr,
           bias_rd_en, bias_rd_addr, out_valid, out_data, out_tap, out_bias, out_first, out_last
  );
endinterface

// File: rtl/stage_mem_seq.sv
// Read-side sequencer for the data/tap/bias stage memories: walks every (output, input)
// pair of a stage and streams operand tuples through a 2-entry skid FIFO.
module stage_mem_seq #(
  parameter int DATA_DEPTH = 64,
  parameter int TAP_DEPTH  = 16,
  parameter int BIAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  stage_mem_seq_if.master bus
);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int TAW = $clog2(TAP_DEPTH);
  localparam int BAW = $clog2(BIAS_DEPTH);
  localparam int NIW = $clog2(DATA_DEPTH + 1);
  localparam int NOW = $clog2(BIAS_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state_reg, state_next;
  logic [NIW-1:0] n_in_reg, n_in_next, i_reg, i_next;
  logic [NOW-1:0] n_out_reg, n_out_next, o_reg, o_next;
  logic [TAW-1:0] tap_reg, tap_next;
  logic           pend_reg, pend_first_reg, pend_last_reg;
  logic           done_reg, done_next;
  logic [1:0]     count_reg, count_next;
  logic           wr_ptr_reg, rd_ptr_reg;

  logic [31:0]    fifo_data_reg  [2];
  logic [191:0]   fifo_tap_reg   [2];
  logic [31:0]    fifo_bias_reg  [2];
  logic [1:0]     fifo_first_reg;
  logic [1:0]     fifo_last_reg;

  logic           pop, issue, in_last, out_last_pair;
  logic [2:0]     occ;

  assign pop = (count_reg != 2'd0) && bus.out_ready;
  // Occupancy after this cycle's pop, counting the read whose data lands this cycle.
  assign occ = {1'b0, count_reg} + {2'b00, pend_reg} - {2'b00, pop};
  assign issue = (state_reg == RUN) && (occ < 3'd2);
  assign in_last = (i_reg == n_in_reg - NIW'(1));
  assign out_last_pair = in_last && (o_reg == n_out_reg - NOW'(1));

  always_comb begin
    state_next = state_reg;
    n_in_next  = n_in_reg;
    n_out_next = n_out_reg;
    i_next     = i_reg;
    o_next     = o_reg;
    tap_next   = tap_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          n_in_next  = bus.cfg_n_in;
          n_out_next = bus.cfg_n_out;
          i_next     = '0;
          o_next     = '0;
          tap_next   = '0;
          if (bus.cfg_n_in == '0 || bus.cfg_n_out == '0) done_next = 1'b1;
          else state_next = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          if (in_last) begin
            i_next = '0;
            o_next = o_reg + NOW'(1);
          end else begin
            i_next = i_reg + NIW'(1);
          end
          tap_next = (tap_reg == TAW'(TAP_DEPTH - 1)) ? '0 : tap_reg + TAW'(1);
          if (out_last_pair) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!pend_reg && occ == 3'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign count_next = count_reg + {1'b0, pend_reg} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      n_in_reg       <= '0;
      n_out_reg      <= '0;
      i_reg          <= '0;
      o_reg          <= '0;
      tap_reg        <= '0;
      pend_reg       <= 1'b0;
      pend_first_reg <= 1'b0;
      pend_last_reg  <= 1'b0;
      done_reg       <= 1'b0;
      count_reg      <= '0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      n_in_reg       <= n_in_next;
      n_out_reg      <= n_out_next;
      i_reg          <= i_next;
      o_reg          <= o_next;
      tap_reg        <= tap_next;
      pend_reg       <= issue;
      pend_first_reg <= issue && (i_reg == '0);
      pend_last_reg  <= issue && in_last;
      done_reg       <= done_next;
      count_reg      <= count_next;
      wr_ptr_reg     <= wr_ptr_reg ^ pend_reg;
      rd_ptr_reg     <= rd_ptr_reg ^ pop;
    end
  end

  // Payload needs no reset: the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (pend_reg) begin
      fifo_data_reg[wr_ptr_reg]  <= bus.data_rd_data;
      fifo_tap_reg[wr_ptr_reg]   <= bus.tap_rd_data;
      fifo_bias_reg[wr_ptr_reg]  <= bus.bias_rd_data;
      fifo_first_reg[wr_ptr_reg] <= pend_first_reg;
      fifo_last_reg[wr_ptr_reg]  <= pend_last_reg;
    end
  end

  assign bus.busy         = (state_reg != IDLE);
  assign bus.done         = done_reg;
  assign bus.data_rd_en   = issue;
  assign bus.tap_rd_en    = issue;
  assign bus.bias_rd_en   = issue;
  assign bus.data_rd_addr = i_reg[DAW-1:0];
  assign bus.tap_rd_addr  = tap_reg;
  assign bus.bias_rd_addr = o_reg[BAW-1:0];

  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_data  = bus.out_valid ? fifo_data_reg[rd_ptr_reg] : '0;
  assign bus.out_tap   = bus.out_valid ? fifo_tap_reg[rd_ptr_reg]  : '0;
  assign bus.out_bias  = bus.out_valid ? fifo_bias_reg[rd_ptr_reg] : '0;
  assign bus.out_first = bus.out_valid && fifo_first_reg[rd_ptr_reg];
  assign bus.out_last  = bus.out_valid && fifo_last_reg[rd_ptr_reg];
endmodule

// File: tb/tb_stage_mem_seq.sv
// Bench for stage_mem_seq: behavioural memories, a tuple-list reference model built from
// the (o, i) walk order, table-driven passes, random passes and hand-written corner cases.
module tb_stage_mem_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stage_mem_seq_if bus();
  stage_mem_seq dut (.clk(clk), .reset(reset), .bus(bus.master));

  typedef struct {
    logic [31:0]  data;
    logic [191:0] tap;
    logic [31:0]  bias;
    logic         first;
    logic         last;
  } tup_t;

  typedef struct {
    int n_in;
    int n_out;
    int rmode;    // 0: ready always, 1: toggling, 2: random
    int exp_n;
    int exp_lat;  // start-to-done cycles, -1 when ready is not constant
  } vec_t;

  tup_t         exp_q[$];
  logic [31:0]  data_mem [64];
  logic [191:0] tap_mem  [16];
  logic [31:0]  bias_mem [8];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int rmode  = 0;
  int issued_cnt = 0, acc_cnt = 0, cur_n_in = 0;
  int start_cyc = 0, first_rd_cyc = -1, first_val_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.data_rd_en) bus.data_rd_data <= data_mem[bus.data_rd_addr];
    if (bus.tap_rd_en)  bus.tap_rd_data  <= tap_mem[bus.tap_rd_addr];
    if (bus.bias_rd_en) bus.bias_rd_data <= bias_mem[bus.bias_rd_addr];
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic         prev_stall = 1'b0;
  logic [31:0]  prev_data, prev_bias;
  logic [191:0] prev_tap;
  logic         prev_first, prev_last;

  always @(negedge clk) begin
    tup_t t;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.data_rd_en || bus.tap_rd_en || bus.bias_rd_en) begin
        check("rd_en_aligned", 256'({bus.data_rd_en, bus.tap_rd_en, bus.bias_rd_en}), 256'(3'b111));
        if (cur_n_in == 0) begin
          check("spurious_rd", 256'(1), 256'(0));
        end else begin
          check("data_addr", 256'(bus.data_rd_addr), 256'(issued_cnt % cur_n_in));
          check("bias_addr", 256'(bus.bias_rd_addr), 256'(issued_cnt / cur_n_in));
          check("tap_addr",  256'(bus.tap_rd_addr),  256'(issued_cnt % 16));
        end
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        issued_cnt++;
      end
      if (prev_stall) begin
        check("stall_valid", 256'(bus.out_valid), 256'(1));
        check("stall_fields", 256'({bus.out_data, bus.out_bias, bus.out_first, bus.out_last}),
              256'({prev_data, prev_bias, prev_first, prev_last}));
        check("stall_tap", 256'(bus.out_tap), 256'(prev_tap));
      end
      if (bus.out_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_tuple", 256'(1), 256'(0));
        end else begin
          t = exp_q.pop_front();
          check("out_data",  256'(bus.out_data),  256'(t.data));
          check("out_tap",   256'(bus.out_tap),   256'(t.tap));
          check("out_bias",  256'(bus.out_bias),  256'(t.bias));
          check("out_first", 256'(bus.out_first), 256'(t.first));
          check("out_last",  256'(bus.out_last),  256'(t.last));
        end
        acc_cnt++;
      end
      if (bus.out_valid || bus.data_rd_en)
        check("outstanding_le2", 256'((issued_cnt - acc_cnt) <= 2), 256'(1));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_tap   = bus.out_tap;
      prev_bias  = bus.out_bias;
      prev_first = bus.out_first;
      prev_last  = bus.out_last;
    end
  end

  task automatic check_idle_zero(input string name);
    check({name, "_ctl"}, 256'({bus.busy, bus.done, bus.data_rd_en, bus.tap_rd_en, bus.bias_rd_en,
                                bus.out_valid, bus.out_first, bus.out_last}), 256'(0));
    check({name, "_addr"}, 256'({bus.data_rd_addr, bus.tap_rd_addr, bus.bias_rd_addr}), 256'(0));
    check({name, "_out"}, 256'({bus.out_data, bus.out_bias}), 256'(0));
    check({name, "_tap"}, 256'(bus.out_tap), 256'(0));
  endtask

  // Builds the expected tuple list from the walk order, then pulses start.
  task automatic start_pass(input int n_in, input int n_out);
    tup_t t;
    @(posedge clk); #1;
    issued_cnt = 0; acc_cnt = 0; cur_n_in = n_in;
    first_rd_cyc = -1; first_val_cyc = -1;
    exp_q.delete();
    for (int k = 0; k < n_in * n_out; k++) begin
      t.data  = data_mem[k % n_in];
      t.tap   = tap_mem[k % 16];
      t.bias  = bias_mem[k / n_in];
      t.first = ((k % n_in) == 0);
      t.last  = ((k % n_in) == n_in - 1);
      exp_q.push_back(t);
    end
    bus.cfg_n_in  = 7'(n_in);
    bus.cfg_n_out = 4'(n_out);
    bus.start     = 1'b1;
    start_cyc     = cyc;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.cfg_n_in  = 7'($urandom_range(0, 64));
    bus.cfg_n_out = 4'($urandom_range(0, 8));
  endtask

  task automatic wait_done(input string tag, input int exp_n, input int exp_lat);
    int done_cyc = -1;
    for (int c = 0; c < exp_n * 8 + 20; c++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
    end
    check("done_seen", 256'(done_cyc >= 0), 256'(1));
    if (done_cyc >= 0) begin
      check("busy_at_done", 256'(bus.busy), 256'(0));
      if (exp_lat >= 0) check("done_latency", 256'(done_cyc - start_cyc), 256'(exp_lat));
      @(negedge clk);
      check("done_pulse", 256'(bus.done), 256'(0));
    end
    check("tuple_count", 256'(acc_cnt), 256'(exp_n));
    check("issue_count", 256'(issued_cnt), 256'(exp_n));
    check("model_empty", 256'(exp_q.size()), 256'(0));
    $display("pass %s: tuples=%0d issued=%0d expected=%0d done_cyc=%0d", tag, acc_cnt, issued_cnt,
             exp_n, done_cyc - start_cyc);
  endtask

  vec_t vecs[8];

  initial begin
    int n_in, n_out, waited;
    for (int k = 0; k < 64; k++) data_mem[k] = $urandom;
    for (int k = 0; k < 16; k++) tap_mem[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 8; k++) bias_mem[k] = $urandom;

    vecs[0] = '{n_in: 4,  n_out: 2, rmode: 0, exp_n: 8,   exp_lat: 11};
    vecs[1] = '{n_in: 5,  n_out: 4, rmode: 0, exp_n: 20,  exp_lat: 23};
    vecs[2] = '{n_in: 3,  n_out: 1, rmode: 1, exp_n: 3,   exp_lat: -1};
    vecs[3] = '{n_in: 0,  n_out: 3, rmode: 0, exp_n: 0,   exp_lat: 1};
    vecs[4] = '{n_in: 6,  n_out: 0, rmode: 0, exp_n: 0,   exp_lat: 1};
    vecs[5] = '{n_in: 1,  n_out: 1, rmode: 0, exp_n: 1,   exp_lat: 4};
    vecs[6] = '{n_in: 64, n_out: 8, rmode: 2, exp_n: 512, exp_lat: -1};
    vecs[7] = '{n_in: 17, n_out: 3, rmode: 1, exp_n: 51,  exp_lat: -1};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.cfg_n_in = '0;
    bus.cfg_n_out = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset_state");
    reset = 1'b0;

    foreach (vecs[v]) begin
      rmode = vecs[v].rmode;
      start_pass(vecs[v].n_in, vecs[v].n_out);
      check("busy_after_start", 256'(bus.busy), 256'(vecs[v].exp_n > 0));
      wait_done($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_lat);
      if (vecs[v].rmode == 0 && vecs[v].exp_n > 0) begin
        check("first_rd_latency", 256'(first_rd_cyc - start_cyc), 256'(1));
        check("first_valid_latency", 256'(first_val_cyc - start_cyc), 256'(3));
      end
    end

    // Start pulse mid-pass with a different configuration must be ignored.
    rmode = 0;
    start_pass(4, 3);
    repeat (3) @(posedge clk);
    #1;
    bus.cfg_n_in = 7'd7;
    bus.cfg_n_out = 4'd2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("restart_ignored", 12, 15);

    // Reset in the middle of a pass, then a fresh short pass.
    start_pass(8, 2);
    waited = 0;
    while (acc_cnt < 5 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("reached_tuple5", 256'(acc_cnt >= 5), 256'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("mid_reset");
    reset = 1'b0;
    $display("reset issued after %0d accepted tuples", acc_cnt);
    start_pass(2, 1);
    wait_done("after_reset", 2, 5);

    // Random configurations under random backpressure.
    for (int r = 0; r < 6; r++) begin
      rmode = 2;
      n_in = $urandom_range(1, 24);
      n_out = $urandom_range(1, 8);
      start_pass(n_in, n_out);
      wait_done($sformatf("rand%0d_%0dx%0d", r, n_in, n_out), n_in * n_out, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
